// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: answers a host start pulse on an open-drain line with a
// 40-bit humidity/temperature frame built from snapshotted measurement bytes.
module dht11_emulator #(
   parameter int CLKS_PER_US   = 50,
   parameter int START_MIN_US  = 18000,
   parameter int RESP_DELAY_US = 30,
   parameter int RESP_LOW_US   = 80,
   parameter int RESP_HIGH_US  = 80,
   parameter int BIT_LOW_US    = 50,
   parameter int BIT0_HIGH_US  = 27,
   parameter int BIT1_HIGH_US  = 70
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire        transmission_line,
   input  logic       respond_enable,
   input  logic       inject_error,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_float,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_float,
   output logic       busy,
   output logic       start_seen,
   output logic       frame_done,
   output logic       drive_low
);

   localparam int CNT_W = 24;
   localparam logic [CNT_W-1:0] START_END = CNT_W'(START_MIN_US  * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(RESP_DELAY_US * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] RLOW_END  = CNT_W'(RESP_LOW_US   * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] RHIGH_END = CNT_W'(RESP_HIGH_US  * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] BLOW_END  = CNT_W'(BIT_LOW_US    * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] B0_END    = CNT_W'(BIT0_HIGH_US  * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] B1_END    = CNT_W'(BIT1_HIGH_US  * CLKS_PER_US - 1);

   typedef enum logic [3:0] {
      IDLE, START_LOW, WAIT_RELEASE, RESP_DELAY, RESP_LOW,
      RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   state_t            state;
   logic              line_s1, line_s2;
   logic [CNT_W-1:0]  cnt;
   logic [39:0]       frame;
   logic [5:0]        bit_idx;
   logic [7:0]        checksum;
   logic [CNT_W-1:0]  high_end;

   assign transmission_line = drive_low ? 1'b0 : 1'bz;
   assign checksum = hum_int + hum_float + temp_int + temp_float;
   // frame[39] is always the bit currently on the wire; the frame shifts left per bit
   assign high_end = frame[39] ? B1_END : B0_END;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         line_s1    <= 1'b1;
         line_s2    <= 1'b1;
         cnt        <= '0;
         frame      <= '0;
         bit_idx    <= '0;
         busy       <= 1'b0;
         start_seen <= 1'b0;
         frame_done <= 1'b0;
         drive_low  <= 1'b0;
      end else begin
         line_s1    <= transmission_line;
         line_s2    <= line_s1;
         start_seen <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!line_s2 && respond_enable) state <= START_LOW;
            end
            START_LOW: begin
               if (line_s2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == START_END) begin
                  state <= WAIT_RELEASE;
                  cnt   <= '0;
               end
            end
            WAIT_RELEASE: begin
               // hold the counter so an arbitrarily long host low cannot wrap it
               cnt <= '0;
               if (line_s2) begin
                  start_seen <= 1'b1;
                  busy       <= 1'b1;
                  frame      <= {hum_int, hum_float, temp_int, temp_float,
                                 checksum ^ {7'b0, inject_error}};
                  state      <= RESP_DELAY;
               end
            end
            RESP_DELAY: if (cnt == DELAY_END) begin
               state     <= RESP_LOW;
               cnt       <= '0;
               drive_low <= 1'b1;
            end
            RESP_LOW: if (cnt == RLOW_END) begin
               state     <= RESP_HIGH;
               cnt       <= '0;
               drive_low <= 1'b0;
            end
            RESP_HIGH: if (cnt == RHIGH_END) begin
               state     <= BIT_LOW;
               cnt       <= '0;
               bit_idx   <= '0;
               drive_low <= 1'b1;
            end
            BIT_LOW: if (cnt == BLOW_END) begin
               state     <= BIT_HIGH;
               cnt       <= '0;
               drive_low <= 1'b0;
            end
            BIT_HIGH: if (cnt == high_end) begin
               frame     <= {frame[38:0], 1'b0};
               cnt       <= '0;
               drive_low <= 1'b1;
               if (bit_idx == 6'd39) begin
                  state <= END_LOW;
               end else begin
                  state   <= BIT_LOW;
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            END_LOW: if (cnt == BLOW_END) begin
               state      <= IDLE;
               cnt        <= '0;
               drive_low  <= 1'b0;
               frame_done <= 1'b1;
               busy       <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               drive_low <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator: a host drives start pulses, and the frame is decoded
// from line timing and compared against a byte-level model.
module tb_dht11_emulator;

   localparam int CLK   = 1;
   localparam int SMIN  = 300;
   localparam int SLEN  = 320;
   localparam int DLY   = 30 * CLK;
   localparam int RL    = 80 * CLK;
   localparam int RH    = 80 * CLK;
   localparam int BL    = 50 * CLK;
   localparam int B0    = 27 * CLK;
   localparam int B1    = 70 * CLK;
   localparam int BTHR  = (B0 + B1) / 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       respond_enable = 1'b1;
   logic       inject_error = 1'b0;
   logic [7:0] hum_int = 8'h00, hum_float = 8'h00, temp_int = 8'h00, temp_float = 8'h00;
   logic       busy, start_seen, frame_done, drive_low;
   logic       host_low = 1'b0;
   wire        transmission_line;

   assign transmission_line = host_low ? 1'b0 : 1'bz;
   pullup (transmission_line);

   dht11_emulator #(
      .CLKS_PER_US(CLK), .START_MIN_US(SMIN), .RESP_DELAY_US(30), .RESP_LOW_US(80),
      .RESP_HIGH_US(80), .BIT_LOW_US(50), .BIT0_HIGH_US(27), .BIT1_HIGH_US(70)
   ) dut (
      .clock(clock), .reset(reset), .transmission_line(transmission_line),
      .respond_enable(respond_enable), .inject_error(inject_error),
      .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int), .temp_float(temp_float),
      .busy(busy), .start_seen(start_seen), .frame_done(frame_done), .drive_low(drive_low)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_bad = 0;
   int n_ss = 0, n_fd = 0;
   int ss0, fd0;

   always @(negedge clock) begin
      if (start_seen) n_ss <= n_ss + 1;
      if (frame_done) n_fd <= n_fd + 1;
   end

   logic [39:0] cap_bits;
   int          cap_lat, cap_bad, cap_to;

   function automatic bit bus_lvl();
      return transmission_line !== 1'b0;
   endfunction

   // Reference: bytes in order, MSB first, checksum is the byte sum mod 256
   function automatic logic [39:0] model(input int hi, input int hf, input int ti, input int tf,
                                         input bit inj);
      int c;
      c = (hi + hf + ti + tf) % 256;
      if (inj) c = c ^ 1;
      return {hi[7:0], hf[7:0], ti[7:0], tf[7:0], c[7:0]};
   endfunction

   task automatic run_until(input bit lvl, input int budget, output int n, output bit to);
      n = 0;
      to = 1'b0;
      do begin
         @(negedge clock);
         n++;
         if (n > budget) begin
            to = 1'b1;
            return;
         end
      end while (bus_lvl() != lvl);
   endtask

   task automatic host_start(input int len);
      @(negedge clock);
      host_low = 1'b1;
      repeat (len) @(negedge clock);
      host_low = 1'b0;
   endtask

   // Decode one frame from line timing; optionally poke hum_int or stop at a given bit
   task automatic capture(input int chg_bit, input logic [7:0] chg_val, input int stop_bit);
      int n;
      bit to;
      cap_bits = '0;
      cap_bad  = 0;
      cap_to   = 0;
      run_until(1'b0, 200, cap_lat, to);
      if (to) begin cap_to++; return; end
      run_until(1'b1, 200, n, to);
      if (to) begin cap_to++; return; end
      if (n != RL) cap_bad++;
      run_until(1'b0, 200, n, to);
      if (to) begin cap_to++; return; end
      if (n != RH) cap_bad++;
      for (int i = 0; i < 40; i++) begin
         if (i == stop_bit) return;
         if (i == chg_bit) hum_int = chg_val;
         run_until(1'b1, 200, n, to);
         if (to) begin cap_to++; return; end
         if (n != BL) cap_bad++;
         run_until(1'b0, 200, n, to);
         if (to) begin cap_to++; return; end
         cap_bits[39-i] = (n > BTHR);
         if (n != ((n > BTHR) ? B1 : B0)) cap_bad++;
      end
      run_until(1'b1, 200, n, to);
      if (to) begin cap_to++; return; end
      if (n != BL) cap_bad++;
   endtask

   task automatic run_frame(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti,
                            input logic [7:0] tf, input bit inj, input int slen,
                            input int chg_bit, input logic [7:0] chg_val, input int stop_bit);
      hum_int = hi; hum_float = hf; temp_int = ti; temp_float = tf; inject_error = inj;
      repeat (20) @(negedge clock);
      ss0 = n_ss;
      fd0 = n_fd;
      host_start(slen);
      capture(chg_bit, chg_val, stop_bit);
      if (stop_bit > 39) repeat (5) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (start_seen !== 1'b0) begin n_bad++; $display("FAIL reset_start_seen got %b want 0", start_seen); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      n_cmp++; if (drive_low !== 1'b0) begin n_bad++; $display("FAIL reset_drive_low got %b want 0", drive_low); end
      n_cmp++; if (bus_lvl() !== 1'b1) begin n_bad++; $display("FAIL reset_line got %b want 1", bus_lvl()); end
      reset = 1'b0;
   endtask

   task automatic check_frame(input string nm, input logic [39:0] exp);
      n_cmp++; if (cap_to !== 0) begin n_bad++; $display("FAIL %s_timeout got %0d want 0", nm, cap_to); end
      n_cmp++; if (cap_bits !== exp) begin n_bad++; $display("FAIL %s_bits got %h want %h", nm, cap_bits, exp); end
      n_cmp++; if (cap_bad !== 0) begin n_bad++; $display("FAIL %s_phase_len got %0d bad want 0", nm, cap_bad); end
      n_cmp++; if (cap_lat < 3 + DLY - 1 || cap_lat > 3 + DLY + 1) begin
         n_bad++; $display("FAIL %s_latency got %0d want %0d+-1", nm, cap_lat, 3 + DLY); end
      n_cmp++; if (n_ss - ss0 !== 1) begin n_bad++; $display("FAIL %s_start_seen got %0d want 1", nm, n_ss - ss0); end
      n_cmp++; if (n_fd - fd0 !== 1) begin n_bad++; $display("FAIL %s_frame_done got %0d want 1", nm, n_fd - fd0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after got %b want 0", nm, busy); end
   endtask

   task automatic test_basic_frame();
      run_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, SLEN, -1, 8'h00, 99);
      n_cmp++; if (model(8'h37, 8'h00, 8'h19, 8'h05, 1'b0) !== cap_bits || cap_bits[7:0] !== 8'h55) begin
         n_bad++; $display("FAIL basic_checksum got %h want 55", cap_bits[7:0]); end
      check_frame("basic", model(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
   endtask

   task automatic test_short_pulse();
      int drv;
      drv = 0;
      repeat (20) @(negedge clock);
      ss0 = n_ss;
      host_start(SMIN / 18);
      repeat (SMIN) begin
         @(negedge clock);
         if (drive_low || busy) drv++;
      end
      n_cmp++; if (drv !== 0) begin n_bad++; $display("FAIL short_driven got %0d cycles want 0", drv); end
      n_cmp++; if (n_ss - ss0 !== 0) begin n_bad++; $display("FAIL short_start_seen got %0d want 0", n_ss - ss0); end
   endtask

   task automatic test_disabled();
      int drv;
      drv = 0;
      respond_enable = 1'b0;
      repeat (20) @(negedge clock);
      ss0 = n_ss;
      host_start(SLEN);
      repeat (10 * SMIN / 18 * 10) begin
         @(negedge clock);
         if (drive_low) drv++;
      end
      n_cmp++; if (drv !== 0) begin n_bad++; $display("FAIL disabled_driven got %0d cycles want 0", drv); end
      n_cmp++; if (n_ss - ss0 !== 0) begin n_bad++; $display("FAIL disabled_start_seen got %0d want 0", n_ss - ss0); end
      respond_enable = 1'b1;
      run_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, SLEN, -1, 8'h00, 99);
      check_frame("reenabled", model(8'h12, 8'h34, 8'h56, 8'h78, 1'b0));
   endtask

   task automatic test_inject_error();
      run_frame(8'h40, 8'h00, 8'h1A, 8'h00, 1'b1, SLEN, -1, 8'h00, 99);
      n_cmp++; if (cap_bits[7:0] !== 8'h5B) begin n_bad++; $display("FAIL inject_checksum got %h want 5b", cap_bits[7:0]); end
      check_frame("inject", model(8'h40, 8'h00, 8'h1A, 8'h00, 1'b1));
      inject_error = 1'b0;
   endtask

   task automatic test_snapshot();
      run_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, SLEN, 3, 8'h50, 99);
      check_frame("snapshot", model(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
   endtask

   task automatic test_reset_abort();
      run_frame(8'hA5, 8'h5A, 8'hFF, 8'h01, 1'b0, SLEN, -1, 8'h00, 20);
      n_cmp++; if (cap_to !== 0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL abort_midframe timeouts %0d busy %b want 0/1", cap_to, busy); end
      reset = 1'b1;
      @(negedge clock);
      n_cmp++; if (bus_lvl() !== 1'b1 || drive_low !== 1'b0) begin
         n_bad++; $display("FAIL abort_release line %b drive_low %b want 1/0", bus_lvl(), drive_low); end
      @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      n_cmp++; if (n_fd - fd0 !== 0) begin n_bad++; $display("FAIL abort_frame_done got %0d want 0", n_fd - fd0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
      run_frame(8'hA5, 8'h5A, 8'hFF, 8'h01, 1'b0, SLEN, -1, 8'h00, 99);
      check_frame("after_abort", model(8'hA5, 8'h5A, 8'hFF, 8'h01, 1'b0));
   endtask

   task automatic test_random();
      logic [7:0] b [4];
      bit inj;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
         inj = 1'($urandom_range(0, 1));
         run_frame(b[0], b[1], b[2], b[3], inj, SMIN + 10 + int'($urandom_range(0, 60)), -1, 8'h00, 99);
         check_frame("random", model(b[0], b[1], b[2], b[3], inj));
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_short_pulse();
      test_disabled();
      test_inject_error();
      test_snapshot();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dht11_emulator.md
# dht11_emulator

Single-wire responder that emulates a DHT11 humidity/temperature sensor on the open-drain `transmission_line`, answering host start pulses with a 40-bit frame built from programmable measurement bytes. It sits on the far end of the bus driven by the DHT11 reader behind the sensor decoder facade. It serves as a loopback target for on-board self-test and as the bus model for the reader's verification bench. Its inputs allow the bench to exercise the reader's normal, checksum-error and timeout paths.

## Interface
- CLKS_PER_US, 50, clock cycles per microsecond (50 MHz system clock)
- START_MIN_US, 18000, minimum host low time accepted as a start request
- RESP_DELAY_US, 30, wait after host release before responding
- RESP_LOW_US, 80, response low phase
- RESP_HIGH_US, 80, response high phase
- BIT_LOW_US, 50, low preamble of each bit and of the end marker
- BIT0_HIGH_US, 27, high time encoding a 0
- BIT1_HIGH_US, 70, high time encoding a 1
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- transmission_line  inout  1  open-drain bus: driven 0 or Z, never 1; external pull-up
- respond_enable  in  1  0 = stay silent (emulates an absent sensor)
- inject_error  in  1  1 = invert checksum bit 0 in the transmitted frame
- hum_int, hum_float, temp_int, temp_float  in  8 each  measurement bytes
- busy  out  1  high from accepted start until end of frame
- start_seen  out  1  one-cycle pulse when a valid start is accepted
- frame_done  out  1  one-cycle pulse when the end-marker low phase completes
- drive_low  out  1  high whenever the block pulls the line low

## Operation
- Line input passes through a 2-flop synchronizer; all decisions use the synchronized value.
- The block drives the line low only when `drive_low`=1; otherwise it drives Z.
- States: IDLE, START_LOW, WAIT_RELEASE, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
- IDLE: on synced low with `respond_enable`=1, enter START_LOW and clear the cycle counter.
- START_LOW: count cycles while the line is low.
  - Line high before START_MIN_US*CLKS_PER_US cycles -> IDLE, no pulses (glitch or short pulse).
  - Reaching the threshold -> WAIT_RELEASE.
- WAIT_RELEASE: on synced high, do all of the following in one cycle, then go to RESP_DELAY:
  - pulse `start_seen` and raise `busy`;
  - snapshot the four input bytes plus checksum = (hum_int+hum_float+temp_int+temp_float) mod 256;
  - apply `inject_error` to the snapshotted checksum.
- RESP_DELAY (released) -> RESP_LOW (driven) -> RESP_HIGH (released) -> BIT_LOW with bit index 0.
- Bit transmission: 40 bits, MSB first, order hum_int, hum_float, temp_int, temp_float, checksum.
  - BIT_LOW is driven for BIT_LOW_US.
  - BIT_HIGH is released for BIT0_HIGH_US or BIT1_HIGH_US according to the snapshot bit.
  - After bit 39 -> END_LOW.
- END_LOW: driven for BIT_LOW_US; on completion release the line, pulse `frame_done`, clear `busy`, return to IDLE.
- From RESP_DELAY through END_LOW the synced line is ignored; host activity cannot abort the frame.
- `respond_enable` is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- Input byte changes after the snapshot do not affect the current frame.

## Timing
- Every timed phase lasts exactly N_US*CLKS_PER_US cycles. The counter is a single cycle counter, at least 20 bits wide, cleared on each state entry.
- First driven-low cycle occurs 2 (synchronizer) + 1 + RESP_DELAY_US*CLKS_PER_US cycles after the host release edge on the raw line. Tolerance ±1 cycle.
- Frame length from RESP_LOW entry = (80+80+40*50+50)us + Σ bit-high times.
- Reset values: `busy`=0, `start_seen`=0, `frame_done`=0, `drive_low`=0, line Z, state IDLE, counters 0.
- Reset asserted mid-frame releases the line on the next clock. No `frame_done` is produced for the aborted frame.
- A host low that continues past START_MIN_US is accepted on its release, whatever its total length.

## Test plan
- Bytes 0x37,0x00,0x19,0x05 with a 20 ms host start -> 40 bits decode to 0x37 00 19 05 55.
  - Check: `start_seen` once, `frame_done` once, `busy` low afterwards.
  - Check: each 0-bit high time = 1350 cycles, each 1-bit high time = 3500 cycles.
- Host low of 1 ms -> no `start_seen`, line never driven, state IDLE.
- `respond_enable`=0 with a 20 ms start -> `drive_low` stays 0 for 10 ms after release; then `respond_enable`=1 and a new start -> full frame.
- `inject_error`=1 with bytes 0x40,0x00,0x1A,0x00 -> transmitted checksum 0x5B instead of 0x5A.
- Change hum_int 0x37->0x50 during bit 3 -> frame still carries 0x37 and checksum 0x55.
- Assert reset during bit 20 -> line Z next cycle, no `frame_done`; the following valid start yields a complete correct frame.
